// File: rtl/traffic_signal_colors_pkg.sv
// traffic_signal_colors_pkg
// Signal colour encoding shared by the signal controller and its safety monitor.
`default_nettype none

package traffic_signal_colors_pkg;
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } color_e;
endpackage

`default_nettype wire

// File: rtl/traffic_conflict_monitor_if.sv
// traffic_conflict_monitor_if
// Controller signal outputs, technician clear and monitor status outputs.
`default_nettype none

interface traffic_conflict_monitor_if;
  import traffic_signal_colors_pkg::*;

  color_e      signal_sb;
  color_e      signal_sb_turn;
  color_e      signal_nb;
  color_e      signal_nb_turn;
  color_e      signal_wb;
  color_e      signal_wb_turn;
  color_e      signal_eb;
  color_e      signal_eb_turn;
  color_e      ped_signal_ns;
  color_e      ped_signal_ew;
  logic        fault_clear;
  logic        flash;
  logic        fault;
  logic [1:0]  fault_code;
  logic [3:0]  fault_source;
  logic        monitor_active;

  modport master (
    output signal_sb, signal_sb_turn, signal_nb, signal_nb_turn,
           signal_wb, signal_wb_turn, signal_eb, signal_eb_turn,
           ped_signal_ns, ped_signal_ew, fault_clear,
    input  flash, fault, fault_code, fault_source, monitor_active
  );

  modport slave (
    input  signal_sb, signal_sb_turn, signal_nb, signal_nb_turn,
           signal_wb, signal_wb_turn, signal_eb, signal_eb_turn,
           ped_signal_ns, ped_signal_ew, fault_clear,
    output flash, fault, fault_code, fault_source, monitor_active
  );
endinterface

`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
// ============================================================================
// traffic_conflict_monitor
// Latching right-of-way conflict and clearance-interval safety monitor.
// Optional macro CONFLICT_MONITOR_PED_EN adds ped signals to the conflict check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_conflict_monitor
  import traffic_signal_colors_pkg::*;
#(
  parameter int MIN_YELLOW     = 3,
  parameter int STARTUP_CYCLES = 6
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  traffic_conflict_monitor_if.slave mon
);

  localparam int c_YW_W = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);
  localparam int c_SC_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [c_YW_W-1:0] c_YMAX  = c_YW_W'(MIN_YELLOW);
  localparam logic [c_SC_W-1:0] c_SLOAD = c_SC_W'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  state_e              r_state;
  logic [c_SC_W-1:0]   r_scnt;
  logic                r_flash;
  logic                r_fault;
  logic [1:0]          r_code;
  logic [3:0]          r_src;
  logic                r_active;
  color_e              r_prev [8];
  logic [c_YW_W-1:0]   r_ycnt [8];

  color_e              w_veh [8];
  logic                w_ns_any;
  logic                w_ew_any;
  logic [3:0]          w_ns_src;
  logic                w_my_hit;
  logic [3:0]          w_my_src;
  logic                w_sy_hit;
  logic [3:0]          w_sy_src;
  logic                w_hit;
  logic [1:0]          w_code;
  logic [3:0]          w_src;
  logic                w_all_red;

  assign w_veh[0] = mon.signal_sb;
  assign w_veh[1] = mon.signal_sb_turn;
  assign w_veh[2] = mon.signal_nb;
  assign w_veh[3] = mon.signal_nb_turn;
  assign w_veh[4] = mon.signal_wb;
  assign w_veh[5] = mon.signal_wb_turn;
  assign w_veh[6] = mon.signal_eb;
  assign w_veh[7] = mon.signal_eb_turn;

`ifndef CONFLICT_MONITOR_PED_EN
  logic [3:0] w_unused_ped;
  assign w_unused_ped = {mon.ped_signal_ns, mon.ped_signal_ew};
`endif

  // Loops run high-to-low so the lowest matching index is the final assignment.
  always_comb begin
    w_ns_any  = 1'b0;
    w_ew_any  = 1'b0;
    w_ns_src  = 4'd0;
    w_my_hit  = 1'b0;
    w_my_src  = 4'd0;
    w_sy_hit  = 1'b0;
    w_sy_src  = 4'd0;
    w_all_red = 1'b1;
`ifdef CONFLICT_MONITOR_PED_EN
    if (mon.ped_signal_ns != RED) begin
      w_ns_any = 1'b1;
      w_ns_src = 4'd8;
    end
    if (mon.ped_signal_ew != RED) w_ew_any = 1'b1;
    if (mon.ped_signal_ns != RED || mon.ped_signal_ew != RED) w_all_red = 1'b0;
`endif
    for (int i = 3; i >= 0; i--) begin
      if (w_veh[i] != RED) begin
        w_ns_any = 1'b1;
        w_ns_src = 4'(i);
      end
    end
    for (int i = 4; i < 8; i++) begin
      if (w_veh[i] != RED) w_ew_any = 1'b1;
    end
    for (int i = 7; i >= 0; i--) begin
      if (w_veh[i] != RED) w_all_red = 1'b0;
      if (r_prev[i] == GREEN && w_veh[i] == RED) begin
        w_my_hit = 1'b1;
        w_my_src = 4'(i);
      end
      if (r_prev[i] == YELLOW && w_veh[i] == RED && r_ycnt[i] < c_YMAX) begin
        w_sy_hit = 1'b1;
        w_sy_src = 4'(i);
      end
    end
    w_hit  = 1'b1;
    w_code = 2'd1;
    w_src  = w_ns_src;
    if (w_ns_any && w_ew_any) begin
      w_code = 2'd1;
      w_src  = w_ns_src;
    end else if (w_my_hit) begin
      w_code = 2'd2;
      w_src  = w_my_src;
    end else if (w_sy_hit) begin
      w_code = 2'd3;
      w_src  = w_sy_src;
    end else begin
      w_hit  = 1'b0;
      w_code = 2'd0;
      w_src  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_STARTUP;
      r_scnt   <= c_SLOAD;
      r_flash  <= 1'b1;
      r_fault  <= 1'b0;
      r_code   <= 2'd0;
      r_src    <= 4'd0;
      r_active <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_prev[i] <= RED;
        r_ycnt[i] <= '0;
      end
    end else begin
      // History tracks in every state so checks are valid on entry to MONITOR.
      for (int i = 0; i < 8; i++) begin
        r_prev[i] <= w_veh[i];
        if (w_veh[i] != YELLOW)        r_ycnt[i] <= '0;
        else if (r_ycnt[i] != c_YMAX)  r_ycnt[i] <= r_ycnt[i] + 1'b1;
      end
      case (r_state)
        ST_STARTUP: begin
          if (r_scnt == '0) begin
            r_state  <= ST_MONITOR;
            r_flash  <= 1'b0;
            r_active <= 1'b1;
          end else begin
            r_scnt <= r_scnt - 1'b1;
          end
        end
        ST_MONITOR: begin
          if (w_hit) begin
            r_state  <= ST_FAULT;
            r_flash  <= 1'b1;
            r_fault  <= 1'b1;
            r_code   <= w_code;
            r_src    <= w_src;
            r_active <= 1'b0;
          end
        end
        ST_FAULT: begin
          if (mon.fault_clear && w_all_red) begin
            r_state <= ST_STARTUP;
            r_scnt  <= c_SLOAD;
            r_fault <= 1'b0;
            r_code  <= 2'd0;
            r_src   <= 4'd0;
          end
        end
        default: begin
          r_state  <= ST_FAULT;
          r_flash  <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign mon.flash          = r_flash;
  assign mon.fault          = r_fault;
  assign mon.fault_code     = r_code;
  assign mon.fault_source   = r_src;
  assign mon.monitor_active = r_active;

endmodule

`default_nettype wire

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Safety monitor directly downstream of `traffic_signal_control_system`. It consumes all ten `color_e` signal outputs every clock (1 Hz) and detects two kinds of fault:
- conflicting right-of-way between the NS and EW approaches;
- illegal clearance: GREEN→RED with no YELLOW, or a YELLOW shorter than the minimum.

On the first fault it latches, drives the intersection to all-red flash and holds until a technician clear.

## Interface
- `MIN_YELLOW`, default 3: minimum consecutive YELLOW samples required before RED on a vehicle signal.
- `STARTUP_CYCLES`, default 6: cycles of forced flash after reset or after a clear.
- `clk`  input  1  system clock, 1 Hz, rising-edge active.
- `reset`  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `signal_sb`, `signal_sb_turn`, `signal_nb`, `signal_nb_turn`, `signal_wb`, `signal_wb_turn`, `signal_eb`, `signal_eb_turn`, `ped_signal_ns`, `ped_signal_ew`  input  `color_e` each  controller outputs (`traffic_signal_colors_pkg`: RED, YELLOW, GREEN).
- `fault_clear`  input  1  technician clear request; level, sampled each edge.
- `flash`  output  1  1 = intersection forced to all-red flash.
- `fault`  output  1  latched fault indicator.
- `fault_code`  output  2  0 none, 1 conflict, 2 missing yellow, 3 short yellow.
- `fault_source`  output  4  index of the offending signal.
  - Indices: 0 sb, 1 sb_turn, 2 nb, 3 nb_turn, 4 wb, 5 wb_turn, 6 eb, 7 eb_turn, 8 ped_ns, 9 ped_ew.
- `monitor_active`  output  1  1 while in MONITOR.

## Operation
- States:
  - STARTUP (reset state).
  - MONITOR.
  - FAULT.
- STARTUP:
  - `flash`=1, checks disabled.
  - Down-counter loaded with STARTUP_CYCLES-1; at 0 → MONITOR.
- MONITOR:
  - `flash`=0, `monitor_active`=1.
  - Evaluates checks on every sampled edge.
  - Any hit → FAULT.
- Conflict check:
  - NS group = {sb, sb_turn, nb, nb_turn}; EW group = {wb, wb_turn, eb, eb_turn}.
  - Fault when any NS member ≠ RED and any EW member ≠ RED in the same sample.
  - `fault_source` = lowest NS-group index that is ≠ RED.
- Clearance checks (vehicle signals 0–7 only):
  - Each signal has a previous-sample register and a YELLOW run counter.
  - The counter is `$clog2(MIN_YELLOW+1)` bits wide, saturates at MIN_YELLOW, and clears on any non-YELLOW sample.
  - prev=GREEN, now=RED → code 2.
  - prev=YELLOW, now=RED, count<MIN_YELLOW → code 3.
  - The previous-sample registers and counters update in every state, so history is valid on entry to MONITOR.
- Simultaneous faults in one sample:
  - Code priority 1 > 2 > 3.
  - Within a code, lowest index wins.
- FAULT:
  - `fault`=1, `flash`=1.
  - `fault_code`/`fault_source` frozen at the first-captured values.
  - Further violations are ignored.
- Clear:
  - In FAULT, `fault_clear`=1 on an edge where all eight vehicle signals sample RED → STARTUP (counter reloaded).
  - On that transition `fault`, `fault_code` and `fault_source` clear to 0.
  - Otherwise stay in FAULT.
  - `fault_clear` is ignored in STARTUP and MONITOR.
- `reset` overrides everything, at any time including mid-FAULT, and returns to STARTUP.

## Timing
- Reset values:
  - state STARTUP, `flash`=1, `fault`=0, `fault_code`=0, `fault_source`=0, `monitor_active`=0.
  - Counters 0; previous-sample registers RED.
- All outputs are registered.
- A violation sampled at edge N appears on `fault`/`fault_code`/`fault_source`/`flash` after edge N; `monitor_active` falls at the same time.
- STARTUP lasts exactly STARTUP_CYCLES edges: `monitor_active` rises after the STARTUP_CYCLES-th edge following reset release.
- Short-yellow boundary, with MIN_YELLOW=3:
  - Exactly 3 YELLOW samples then RED → legal.
  - 2 YELLOW samples then RED → code 3.
- YELLOW→GREEN is not checked.
- A YELLOW run spanning the STARTUP→MONITOR transition counts in full.

## Configuration
- `CONFLICT_MONITOR_PED_EN`:
  - Defined: `ped_signal_ns` joins the NS group and `ped_signal_ew` joins the EW group for the conflict check only (index 8 can become `fault_source`). The clear condition also requires both ped signals RED.
  - Undefined: ped inputs remain ports but are ignored entirely.
  - Ped signals never get clearance checks.

## Test plan
Parameters for all scenarios: MIN_YELLOW=3, STARTUP_CYCLES=6.
- **Reset and startup:** reset 1 cycle, all signals RED → `flash`=1 for 6 edges, then `monitor_active`=1, `flash`=0, `fault`=0.
- **Legal cycle:** sb/nb GREEN 10, YELLOW 3, RED; then wb/eb GREEN → no fault across 40 cycles.
- **Conflict:** in MONITOR, drive nb_turn=GREEN and eb=GREEN in one sample → after that edge `fault`=1, `fault_code`=1, `fault_source`=3, `flash`=1.
- **Clearance faults (separate runs):**
  - wb GREEN→RED directly → code 2, source 4.
  - eb_turn YELLOW 2 cycles then RED → code 3, source 7.
  - Simultaneously sb GREEN→RED and nb YELLOW(1)→RED → code 2, source 0.
- **Clear:**
  - In FAULT, `fault_clear`=1 with sb=GREEN → stays FAULT.
  - Then all RED plus `fault_clear`=1 → STARTUP, fault fields 0, `monitor_active` after 6 edges.
  - `reset` asserted mid-FAULT → same STARTUP behaviour.
- **Ped macro:** with `CONFLICT_MONITOR_PED_EN`, ped_ns=GREEN and wb=GREEN → code 1, source 8. Without the macro, the same stimulus → no fault.
